// File: rtl/params_pkg.sv
// Shared widths, arbiter defaults and state/owner types for the CPU memory subsystem.
package params_pkg;

    localparam int ADDR_WIDTH           = 32;
    localparam int DATA_WIDTH           = 32;
    localparam int MAX_D_STREAK_DEFAULT = 4;
    localparam int TIMEOUT_DEFAULT      = 64;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE_I = 3'd1,
        ISSUE_D = 3'd2,
        WAIT_I  = 3'd3,
        WAIT_D  = 3'd4
    } arb_state_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } arb_owner_t;

    function automatic logic is_wait(input arb_state_t s);
        return (s == WAIT_I) || (s == WAIT_D);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the fetch port, data port, arbiter and unified memory.
interface mem_arbiter_if;
    import params_pkg::*;

    logic                  if_req_valid;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_resp_valid;
    logic [DATA_WIDTH-1:0] if_rdata;

    logic                  d_req_valid;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_resp_valid;
    logic [DATA_WIDTH-1:0] d_rdata;

    logic                  mem_req_valid;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_resp_valid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  if_req_valid, if_addr, d_req_valid, d_we, d_addr, d_wdata,
        input  mem_resp_valid, mem_rdata,
        output if_resp_valid, if_rdata, d_resp_valid, d_rdata,
        output mem_req_valid, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req_valid, if_addr, d_req_valid, d_we, d_addr, d_wdata,
        output mem_resp_valid, mem_rdata,
        input  if_resp_valid, if_rdata, d_resp_valid, d_rdata,
        input  mem_req_valid, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/arb_priority.sv
// Two-requester pick: data wins unless it has already taken MAX_D_STREAK grants past a waiting fetch.
module arb_priority
    import params_pkg::*;
#(
    parameter int MAX_D_STREAK = MAX_D_STREAK_DEFAULT,
    parameter int STREAK_W     = $clog2(MAX_D_STREAK + 1)
) (
    input  logic                if_req,
    input  logic                d_req,
    input  logic [STREAK_W-1:0] streak,
    output logic                grant,
    output arb_owner_t          owner
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    // priority decision
    always_comb begin
        grant = 1'b0;
        owner = OWNER_I;
        if (d_req && if_req) begin
            grant = 1'b1;
            owner = (streak < STREAK_MAX) ? OWNER_D : OWNER_I;
        end else if (d_req) begin
            grant = 1'b1;
            owner = OWNER_D;
        end else if (if_req) begin
            grant = 1'b1;
            owner = OWNER_I;
        end else begin
            grant = 1'b0;
            owner = OWNER_I;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch and data requests onto one single-port memory, one transaction in flight,
// routing each response to its owner and flagging stray responses and timeouts.
module mem_arbiter
    import params_pkg::*;
#(
    parameter int MAX_D_STREAK = MAX_D_STREAK_DEFAULT,
    parameter int TIMEOUT      = TIMEOUT_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus,
    output logic          err_o
);

    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam int TIMER_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
    localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    arb_state_t            state_r, state_s;
    logic [STREAK_W-1:0]   streak_r, streak_s;
    logic [TIMER_W-1:0]    timer_r, timer_s;
    logic                  err_r, err_s;
    logic                  mem_req_r, mem_req_s;
    logic                  mem_we_r, mem_we_s;
    logic [ADDR_WIDTH-1:0] mem_addr_r, mem_addr_s;
    logic [DATA_WIDTH-1:0] mem_wdata_r, mem_wdata_s;

    logic                  grant_s;
    arb_owner_t            owner_s;

    arb_priority #(
        .MAX_D_STREAK (MAX_D_STREAK),
        .STREAK_W     (STREAK_W)
    ) u_priority (
        .if_req (bus.if_req_valid),
        .d_req  (bus.d_req_valid),
        .streak (streak_r),
        .grant  (grant_s),
        .owner  (owner_s)
    );

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            streak_r    <= '0;
            timer_r     <= '0;
            err_r       <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
        end else begin
            state_r     <= state_s;
            streak_r    <= streak_s;
            timer_r     <= timer_s;
            err_r       <= err_s;
            mem_req_r   <= mem_req_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
        end
    end

    // next-state, grant capture, streak and timeout bookkeeping
    always_comb begin
        state_s     = state_r;
        streak_s    = streak_r;
        timer_s     = timer_r;
        err_s       = err_r;
        mem_req_s   = 1'b0;
        mem_we_s    = mem_we_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;

        // a response with nothing waiting for it is a protocol error
        if (bus.mem_resp_valid && !is_wait(state_r)) begin
            err_s = 1'b1;
        end else begin
            err_s = err_r;
        end

        case (state_r)
            IDLE: begin
                if (grant_s) begin
                    mem_req_s = 1'b1;
                    timer_s   = '0;
                    if (owner_s == OWNER_D) begin
                        state_s     = ISSUE_D;
                        mem_we_s    = bus.d_we;
                        mem_addr_s  = bus.d_addr;
                        mem_wdata_s = bus.d_wdata;
                        if (bus.if_req_valid) begin
                            streak_s = (streak_r < STREAK_MAX) ? streak_r + STREAK_W'(1) : streak_r;
                        end else begin
                            streak_s = '0;
                        end
                    end else begin
                        state_s     = ISSUE_I;
                        mem_we_s    = 1'b0;
                        mem_addr_s  = bus.if_addr;
                        mem_wdata_s = '0;
                        streak_s    = '0;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE_I: begin
                state_s = WAIT_I;
            end
            ISSUE_D: begin
                state_s = WAIT_D;
            end
            WAIT_I, WAIT_D: begin
                if (bus.mem_resp_valid) begin
                    state_s = IDLE;
                end else if (timer_r == TIMER_LAST) begin
                    err_s   = 1'b1;
                    state_s = IDLE;
                end else begin
                    timer_s = timer_r + TIMER_W'(1);
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // responses pass straight through so the owner sees them in the memory's response cycle
    always_comb begin
        bus.if_resp_valid = 1'b0;
        bus.if_rdata      = '0;
        bus.d_resp_valid  = 1'b0;
        bus.d_rdata       = '0;
        if (bus.mem_resp_valid && (state_r == WAIT_I)) begin
            bus.if_resp_valid = 1'b1;
            bus.if_rdata      = bus.mem_rdata;
        end else if (bus.mem_resp_valid && (state_r == WAIT_D)) begin
            bus.d_resp_valid = 1'b1;
            bus.d_rdata      = mem_we_r ? '0 : bus.mem_rdata;
        end else begin
            bus.if_resp_valid = 1'b0;
            bus.d_resp_valid  = 1'b0;
        end
    end

    assign bus.mem_req_valid = mem_req_r;
    assign bus.mem_we        = mem_we_r;
    assign bus.mem_addr      = mem_addr_r;
    assign bus.mem_wdata     = mem_wdata_r;
    assign err_o             = err_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: bench-side memory, requesters and a reference memory image.
module tb_mem_arbiter;

    localparam int D_STREAK = 4;
    localparam int TMO      = 64;

    logic clk = 1'b0;
    logic rst;
    logic err_o;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .MAX_D_STREAK (D_STREAK),
        .TIMEOUT      (TMO)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .err_o (err_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] ref_mem  [logic [31:0]];
    logic [31:0] phys_mem [logic [31:0]];
    logic [31:0] if_exp [$];
    logic [31:0] d_exp  [$];

    int if_resp_cnt = 0;
    int d_resp_cnt  = 0;
    int if_seen     = 0;
    int d_seen      = 0;
    int d_at_if     = 0;
    int resp_cd     = 0;
    logic [31:0] resp_data = 32'd0;
    int mem_lat       = 1;
    bit lat_rand      = 1'b0;
    bit rand_on       = 1'b0;
    int d_reload_left = 0;
    int streak_m      = 0;
    bit prev_if = 1'b0, prev_d = 1'b0, prev_mreq = 1'b0;

    function automatic logic [31:0] img(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[15:0]};
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return img(a);
    endfunction

    function automatic logic [31:0] phys_rd(input logic [31:0] a);
        if (phys_mem.exists(a)) return phys_mem[a];
        return img(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        ref_mem[a]  = v;
        phys_mem[a] = v;
    endtask

    task automatic new_fetch(input logic [31:0] a);
        bus.if_req_valid = 1'b1;
        bus.if_addr      = a;
        if_exp.push_back(ref_rd(a));
    endtask

    task automatic new_data(input bit we, input logic [31:0] a, input logic [31:0] wd, input bit push);
        bus.d_req_valid = 1'b1;
        bus.d_we        = we;
        bus.d_addr      = a;
        bus.d_wdata     = wd;
        if (push) begin
            if (we) begin
                ref_mem[a] = wd;
                d_exp.push_back(32'd0);
            end else begin
                d_exp.push_back(ref_rd(a));
            end
        end
    endtask

    // One clock of bench activity: memory model, then requesters.
    task automatic cyc();
        @(posedge clk);
        #1;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = $urandom;
        if (resp_cd > 0) begin
            resp_cd--;
            if (resp_cd == 0) begin
                bus.mem_resp_valid = 1'b1;
                bus.mem_rdata      = resp_data;
            end
        end
        if (bus.mem_req_valid && rst) begin
            if (bus.mem_we) begin
                phys_mem[bus.mem_addr] = bus.mem_wdata;
                resp_data = $urandom;
            end else begin
                resp_data = phys_rd(bus.mem_addr);
            end
            resp_cd = lat_rand ? int'($urandom_range(1, 4)) : mem_lat;
        end
        if (if_resp_cnt != if_seen) begin
            if_seen = if_resp_cnt;
            bus.if_req_valid = 1'b0;
        end
        if (d_resp_cnt != d_seen) begin
            d_seen = d_resp_cnt;
            bus.d_req_valid = 1'b0;
            if (d_reload_left > 0) begin
                d_reload_left--;
                new_data(1'b0, bus.d_addr + 32'd1, $urandom, 1'b1);
            end
        end
        if (rand_on) begin
            if (!bus.if_req_valid && ($urandom_range(0, 2) == 0))
                new_fetch(32'($urandom_range(0, 255)));
            if (!bus.d_req_valid && ($urandom_range(0, 1) == 0))
                new_data(1'($urandom_range(0, 1)), 32'h100 + 32'($urandom_range(0, 15)), $urandom, 1'b1);
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((bus.if_req_valid || bus.d_req_valid || if_exp.size() != 0 || d_exp.size() != 0) && n < budget) begin
            cyc();
            n++;
        end
        check("drain_within_budget", 32'(n < budget), 32'd1);
    endtask

    // Grant check: owner from the sampled request lines and the fetch-starvation rule.
    task automatic check_grant();
        bit exp_d;
        check("mem_req_single_cycle", 32'(prev_mreq), 32'd0);
        if (!prev_if && !prev_d) begin
            check("mem_req_spurious", 32'(bus.mem_req_valid), 32'd0);
        end else begin
            exp_d = prev_d && (!prev_if || streak_m < D_STREAK);
            if (exp_d) begin
                check("grant_d_addr", bus.mem_addr, bus.d_addr);
                check("grant_d_we", 32'(bus.mem_we), 32'(bus.d_we));
                check("grant_d_wdata", bus.mem_wdata, bus.d_wdata);
                streak_m = prev_if ? ((streak_m < D_STREAK) ? streak_m + 1 : streak_m) : 0;
            end else begin
                check("grant_i_addr", bus.mem_addr, bus.if_addr);
                check("grant_i_we", 32'(bus.mem_we), 32'd0);
                check("grant_i_wdata", bus.mem_wdata, 32'd0);
                streak_m = 0;
            end
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst) begin
                streak_m  = 0;
                prev_mreq = 1'b0;
            end else begin
                if (bus.if_resp_valid) begin
                    if_resp_cnt++;
                    d_at_if = d_resp_cnt;
                    if (if_exp.size() == 0) check("if_resp_unexpected", 32'(bus.if_resp_valid), 32'd0);
                    else check("if_rdata", bus.if_rdata, if_exp.pop_front());
                end
                if (bus.d_resp_valid) begin
                    d_resp_cnt++;
                    if (d_exp.size() == 0) check("d_resp_unexpected", 32'(bus.d_resp_valid), 32'd0);
                    else check("d_rdata", bus.d_rdata, d_exp.pop_front());
                end
                if (bus.mem_req_valid) check_grant();
                prev_mreq = bus.mem_req_valid;
            end
            prev_if = bus.if_req_valid;
            prev_d  = bus.d_req_valid;
        end
    endtask

    initial begin
        int d_base;
        rst = 1'b0;
        bus.if_req_valid   = 1'b0;
        bus.if_addr        = 32'd0;
        bus.d_req_valid    = 1'b0;
        bus.d_we           = 1'b0;
        bus.d_addr         = 32'd0;
        bus.d_wdata        = 32'd0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = 32'd0;
        fork
            monitor();
        join_none

        repeat (3) cyc();
        check("rst_mem_req", 32'(bus.mem_req_valid), 32'd0);
        check("rst_if_resp", 32'(bus.if_resp_valid), 32'd0);
        check("rst_d_resp", 32'(bus.d_resp_valid), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        rst = 1'b1;
        cyc();

        // fetch only, 2-cycle memory
        preload(32'h1, 32'h4470);
        mem_lat = 2;
        new_fetch(32'h1);
        cyc();
        check("t1_req_at_t1", 32'(bus.mem_req_valid), 32'd1);
        check("t1_addr", bus.mem_addr, 32'h1);
        check("t1_we", 32'(bus.mem_we), 32'd0);
        cyc();
        check("t1_req_one_cycle", 32'(bus.mem_req_valid), 32'd0);
        cyc();
        #1;
        check("t1_resp_at_t3", 32'(bus.if_resp_valid), 32'd1);
        check("t1_rdata", bus.if_rdata, 32'h4470);
        wait_drain(20);
        check("t1_err", 32'(err_o), 32'd0);

        // simultaneous fetch and store: store first, fetch three cycles later
        mem_lat = 1;
        new_fetch(32'h2);
        new_data(1'b1, 32'h10, 32'hD, 1'b1);
        cyc();
        check("t2_store_first_req", 32'(bus.mem_req_valid), 32'd1);
        check("t2_store_we", 32'(bus.mem_we), 32'd1);
        check("t2_store_addr", bus.mem_addr, 32'h10);
        check("t2_store_wdata", bus.mem_wdata, 32'hD);
        cyc();
        #1;
        check("t2_store_ack", 32'(bus.d_resp_valid), 32'd1);
        check("t2_store_rdata_zero", bus.d_rdata, 32'd0);
        cyc();
        check("t2_gap", 32'(bus.mem_req_valid), 32'd0);
        cyc();
        check("t2_fetch_req", 32'(bus.mem_req_valid), 32'd1);
        check("t2_fetch_addr", bus.mem_addr, 32'h2);
        wait_drain(20);

        // streak limit: fetch held against back-to-back loads
        d_base = d_resp_cnt;
        new_fetch(32'h3);
        new_data(1'b0, 32'h20, $urandom, 1'b1);
        d_reload_left = 5;
        wait_drain(200);
        check("t3_loads_before_fetch", 32'(d_at_if - d_base), 32'd4);
        check("t3_total_loads", 32'(d_resp_cnt - d_base), 32'd6);

        // timeout on a load that memory never answers
        mem_lat = 0;
        new_data(1'b0, 32'h30, 32'd0, 1'b0);
        cyc();
        check("t4_req", 32'(bus.mem_req_valid), 32'd1);
        repeat (TMO) cyc();
        check("t4_err_not_early", 32'(err_o), 32'd0);
        cyc();
        check("t4_err_set", 32'(err_o), 32'd1);
        bus.d_req_valid = 1'b0;
        mem_lat = 1;
        new_fetch(32'h7);
        cyc();
        check("t4_back_idle_req", 32'(bus.mem_req_valid), 32'd1);
        check("t4_back_idle_addr", bus.mem_addr, 32'h7);
        wait_drain(20);

        // reset during WAIT_D abandons the load
        mem_lat = 3;
        new_data(1'b0, 32'h40, 32'd0, 1'b0);
        cyc();
        cyc();
        rst = 1'b0;
        resp_cd = 0;
        bus.d_req_valid = 1'b0;
        cyc();
        check("t5_mem_req", 32'(bus.mem_req_valid), 32'd0);
        check("t5_d_resp", 32'(bus.d_resp_valid), 32'd0);
        check("t5_mem_addr", bus.mem_addr, 32'd0);
        check("t5_mem_we", 32'(bus.mem_we), 32'd0);
        check("t5_err_cleared", 32'(err_o), 32'd0);
        rst = 1'b1;
        mem_lat = 1;
        new_fetch(32'h5);
        wait_drain(20);
        check("t5_err_after", 32'(err_o), 32'd0);

        // stray response in IDLE, then random traffic keeps err_o sticky
        cyc();
        bus.mem_resp_valid = 1'b1;
        cyc();
        check("t6_stray_err", 32'(err_o), 32'd1);
        lat_rand = 1'b1;
        rand_on  = 1'b1;
        repeat (1500) cyc();
        rand_on = 1'b0;
        wait_drain(100);
        check("t6_err_sticky", 32'(err_o), 32'd1);

        rst = 1'b0;
        repeat (2) cyc();
        rst = 1'b1;
        check("t7_err_reset", 32'(err_o), 32'd0);
        rand_on = 1'b1;
        repeat (1500) cyc();
        rand_on = 1'b0;
        wait_drain(100);
        check("t7_err_clean", 32'(err_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
